// File: rtl/comparator_pkg.sv
// Shared types and constants for the comparator BIST: state names, LFSR taps and seed,
// and the equality-forcing period.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_POLY_TAPS  = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED    = 16'hACE1;
    localparam int          EQ_FORCE_PERIOD = 4;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_POLY_TAPS)};
    endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// Operand/flag bus between the BIST and the magnitude comparator under test.
interface comparator_bist_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic             D;
    logic             E;

    modport master (output A, output B, input C, input D, input E);
    modport slave  (input A, input B, output C, output D, output E);
endinterface

// File: rtl/bist_lfsr16.sv
// 16-bit Fibonacci LFSR; reset loads the seed, en advances one step.
module bist_lfsr16
    import comparator_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state = lfsr_q;

endmodule

// File: rtl/comparator_bist.sv
// Self-test driver/checker for a magnitude comparator: drives LFSR operand pairs,
// waits SETTLE cycles, checks the C/D/E flags and reports a pass/fail summary.
module comparator_bist
    import comparator_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          NUM_VECTORS = 16,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    comparator_bist_if.master        cmp,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [7:0]               err_count,
    output logic [7:0]               vec_count
);

    localparam logic [1:0]  S_IDLE    = IDLE;
    localparam logic [1:0]  S_WAIT    = WAIT;
    localparam logic [1:0]  S_CHECK   = CHECK;
    localparam logic [1:0]  S_DONE    = DONE;
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [3:0]  SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [7:0]  LAST_VEC  = 8'(NUM_VECTORS - 1);
    localparam logic [7:0]  EQ_PER    = 8'(EQ_FORCE_PERIOD);

    logic [1:0]       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [7:0]       err_q, err_d;
    logic [7:0]       vec_q, vec_d;

    logic [15:0]      lfsr_state;
    logic             lfsr_unused;
    logic             load_vec;
    logic [7:0]       load_idx;
    logic [2:0]       exp_flags;
    logic             mismatch;
    logic [7:0]       err_next;

    bist_lfsr16 #(.SEED(SEED_EFF)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (load_vec),
        .state (lfsr_state)
    );

    // Only the low and high slices feed the operands; middle bits just circulate.
    assign lfsr_unused = ^lfsr_state;

    assign exp_flags = {a_q > b_q, a_q == b_q, a_q < b_q};
    assign mismatch  = ({cmp.C, cmp.D, cmp.E} != exp_flags);
    assign err_next  = (mismatch && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        vec_d    = vec_q;
        load_vec = 1'b0;
        load_idx = 8'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_vec = 1'b1;
                    load_idx = 8'd0;
                    err_d    = 8'd0;
                    vec_d    = 8'd0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    settle_d = SETTLE_LD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                err_d = err_next;
                vec_d = vec_q + 8'd1;
                if (vec_q == LAST_VEC) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == 8'd0);
                    state_d = S_DONE;
                end else begin
                    load_vec = 1'b1;
                    load_idx = vec_q + 8'd1;
                    settle_d = SETTLE_LD;
                    state_d  = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Every EQ_PER-th vector mirrors A onto B so the equality flag gets exercised.
        if (load_vec) begin
            a_d = lfsr_state[WIDTH-1:0];
            if ((load_idx % EQ_PER) == (EQ_PER - 8'd1)) begin
                b_d = lfsr_state[WIDTH-1:0];
            end else begin
                b_d = lfsr_state[15 -: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            settle_q <= 4'd0;
            a_q      <= '0;
            b_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 8'd0;
            vec_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            vec_q    <= vec_d;
        end
    end

    assign cmp.A     = a_q;
    assign cmp.B     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign vec_count = vec_q;

endmodule

// File: tb/tb_comparator_bist.sv
// Four BIST instances against golden, D-stuck-0, C/E-swapped and 2-cycle-delayed comparators.
module tb_comparator_bist;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    comparator_bist_if #(.WIDTH(4)) if_g ();
    comparator_bist_if #(.WIDTH(4)) if_s ();
    comparator_bist_if #(.WIDTH(4)) if_w ();
    comparator_bist_if #(.WIDTH(4)) if_d ();

    assign if_g.C = (if_g.A > if_g.B);
    assign if_g.D = (if_g.A == if_g.B);
    assign if_g.E = (if_g.A < if_g.B);

    assign if_s.C = (if_s.A > if_s.B);
    assign if_s.D = 1'b0;
    assign if_s.E = (if_s.A < if_s.B);

    assign if_w.C = (if_w.A < if_w.B);
    assign if_w.D = (if_w.A == if_w.B);
    assign if_w.E = (if_w.A > if_w.B);

    logic [2:0] dly1, dly2;
    always @(posedge clk) begin
        dly1 <= {if_d.A > if_d.B, if_d.A == if_d.B, if_d.A < if_d.B};
        dly2 <= dly1;
    end
    assign {if_d.C, if_d.D, if_d.E} = dly2;

    logic       busy [4];
    logic       done [4];
    logic       pass [4];
    logic [7:0] errc [4];
    logic [7:0] vecc [4];

    comparator_bist u_gold (
        .clk(clk), .rst(rst), .start(start), .cmp(if_g),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errc[0]), .vec_count(vecc[0]));
    comparator_bist #(.NUM_VECTORS(8)) u_stk (
        .clk(clk), .rst(rst), .start(start), .cmp(if_s),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errc[1]), .vec_count(vecc[1]));
    comparator_bist u_swp (
        .clk(clk), .rst(rst), .start(start), .cmp(if_w),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errc[2]), .vec_count(vecc[2]));
    comparator_bist #(.SETTLE(3)) u_dly (
        .clk(clk), .rst(rst), .start(start), .cmp(if_d),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errc[3]), .vec_count(vecc[3]));

    // Reference model: per-instance generator state, vector lists and expected error totals.
    int          exp_n [4] = '{16, 8, 16, 16};
    int          exp_s [4] = '{1, 1, 1, 3};
    logic [15:0] mst   [4];
    int          exp_err [4];
    logic [3:0]  ref_a [256];
    logic [3:0]  ref_b [256];

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic model_seed();
        for (int d = 0; d < 4; d++) mst[d] = 16'hACE1;
    endtask

    task automatic model_runs();
        for (int d = 0; d < 4; d++) begin
            logic [15:0] s;
            int          eq;
            s  = mst[d];
            eq = 0;
            for (int k = 0; k < exp_n[d]; k++) begin
                logic [3:0] a, b;
                a = 4'(s & 16'h000F);
                b = (k % 4 == 3) ? a : 4'(s >> 12);
                if (d == 0) begin
                    ref_a[k] = a;
                    ref_b[k] = b;
                end
                if (a == b) eq++;
                s = lfsr_step(s);
            end
            mst[d] = s;
            // stuck D misses every equal pair; swapped C/E misses every unequal pair
            exp_err[d] = (d == 1) ? eq : (d == 2) ? exp_n[d] - eq : 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if ({busy[d], done[d], pass[d], errc[d], vecc[d]} !== 19'd0) begin
                n_fail++;
                $display("FAIL reset_outs[%0d]: got %0h want 0", d, {busy[d], done[d], pass[d], errc[d], vecc[d]});
            end
        end
        n_tests++;
        if ({if_g.A, if_g.B} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ab: got %0h want 0", {if_g.A, if_g.B});
        end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        model_seed();
    endtask

    task automatic test_idle_hold();
        repeat ($urandom_range(2, 9)) @(posedge clk);
        #1;
        n_tests++;
        if ({if_g.A, if_g.B, busy[0], done[0], vecc[0]} !== 18'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got %0h want 0", {if_g.A, if_g.B, busy[0], done[0], vecc[0]});
        end
    endtask

    task automatic test_full_run(input string tag);
        int done_edge [4];
        for (int d = 0; d < 4; d++) done_edge[d] = -1;
        model_runs();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_tests++;
        if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL %s start_busy: got busy=%0b done=%0b want busy=1 done=0", tag, busy[0], done[0]);
        end
        for (int e = 1; e <= 80; e++) begin
            // start during WAIT/CHECK must be ignored by every instance
            if (e < 14 && $urandom_range(0, 3) == 0) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int d = 0; d < 4; d++)
                if (done[d] === 1'b1 && done_edge[d] < 0) done_edge[d] = e;
            if (e % 2 == 1 && e < 32) begin
                int k;
                k = e / 2;
                n_tests++;
                if (if_g.A !== ref_a[k] || if_g.B !== ref_b[k] || vecc[0] !== 8'(k)) begin
                    n_fail++;
                    $display("FAIL %s vec%0d: got A=%0h B=%0h vc=%0d want A=%0h B=%0h vc=%0d",
                             tag, k, if_g.A, if_g.B, vecc[0], ref_a[k], ref_b[k], k);
                end
                if (k % 4 == 3) begin
                    n_tests++;
                    if (if_g.D !== 1'b1) begin
                        n_fail++;
                        $display("FAIL %s forced_eq%0d: got D=%0b want 1", tag, k, if_g.D);
                    end
                end
            end
        end
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if (done_edge[d] != exp_n[d] * (exp_s[d] + 1)) begin
                n_fail++;
                $display("FAIL %s done_edge[%0d]: got %0d want %0d", tag, d, done_edge[d], exp_n[d] * (exp_s[d] + 1));
            end
            n_tests++;
            if (errc[d] !== 8'(exp_err[d]) || pass[d] !== (exp_err[d] == 0) ||
                vecc[d] !== 8'(exp_n[d]) || busy[d] !== 1'b0 || done[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL %s result[%0d]: got err=%0d pass=%0b vc=%0d busy=%0b done=%0b want err=%0d pass=%0b vc=%0d busy=0 done=1",
                         tag, d, errc[d], pass[d], vecc[d], busy[d], done[d], exp_err[d], exp_err[d] == 0, exp_n[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] err_hold;
        err_hold = 8'(exp_err[2]);
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
        n_tests++;
        if (done[2] !== 1'b1 || errc[2] !== err_hold) begin
            n_fail++;
            $display("FAIL done_hold: got done=%0b err=%0d want done=1 err=%0d", done[2], errc[2], err_hold);
        end
        test_full_run("run2");
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 4; d++) begin
            n_tests++;
            if ({busy[d], done[d], pass[d], errc[d], vecc[d]} !== 19'd0) begin
                n_fail++;
                $display("FAIL midrun_rst[%0d]: got %0h want 0", d, {busy[d], done[d], pass[d], errc[d], vecc[d]});
            end
        end
        n_tests++;
        if ({if_g.A, if_g.B} !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_rst_ab: got %0h want 0", {if_g.A, if_g.B});
        end
        #2 rst = 1'b0;
        model_seed();
        @(posedge clk);
        #1;
        test_full_run("rerun");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle_hold();
        test_full_run("run1");
        test_back_to_back();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
